// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, the round-stage FSM encoding and
// the inverse S-box lookup used by the decryption datapath.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int BYTE_W      = 8;
  localparam int AES_BYTES   = AES_STATE_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Row-major 16x16 table; leftmost byte is entry 0x00.
  localparam logic [0:255][BYTE_W-1:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [BYTE_W-1:0] inv_sbox_f(input logic [BYTE_W-1:0] b);
    return INV_SBOX_TBL[b];
  endfunction

  // Bit position of the MSB of state byte idx (byte0 sits at the top).
  function automatic int byte_msb(input int idx);
    return AES_STATE_W - 1 - idx * BYTE_W;
  endfunction

endpackage

// File: rtl/inv_subbytes_iter_if.sv
// Valid/ready bus between the round controller and the InvSubBytes stage:
// an input channel (state in) and an output channel (substituted state out).
interface inv_subbytes_iter_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] inputdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] outputdata;

    modport master (
        output in_valid, inputdata, out_ready,
        input  in_ready, out_valid, outputdata
    );

    modport slave (
        input  in_valid, inputdata, out_ready,
        output in_ready, out_valid, outputdata
    );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    assign dout = inv_sbox_f(din);

endmodule

// File: rtl/inv_subbytes_iter.sv
// Iterative InvSubBytes: substitutes LANES bytes of the 128-bit state per cycle,
// byte0 first, and presents the finished state only once all 16 bytes are done.
module inv_subbytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inv_subbytes_iter_if.slave  bus
);

    localparam int                NSTEP     = AES_BYTES / LANES;
    localparam int                STEP_W    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_state_e                     state_q, state_d;
    logic [STEP_W-1:0]              step_q, step_d;
    logic [AES_STATE_W-1:0]         data_q, data_d;
    logic [LANES-1:0][BYTE_W-1:0]   lane_in;
    logic [LANES-1:0][BYTE_W-1:0]   lane_out;

    // Byte mux: the step counter selects which LANES bytes feed the S-boxes.
    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = data_q[byte_msb(int'(step_q) * LANES + l) -: BYTE_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        step_d         = step_q;
        data_d         = data_q;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.outputdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                // NOTE: gated by rst_n so in_ready reads 0 while reset is held,
                // even though the register already sits in IDLE.
                bus.in_ready = rst_n;
                if (bus.in_valid) begin
                    data_d  = bus.inputdata;
                    step_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[byte_msb(int'(step_q) * LANES + l) -: BYTE_W] = lane_out[l];
                end
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                bus.out_valid  = 1'b1;
                bus.outputdata = data_q;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/inv_subbytes_iter.md
Name: inv_subbytes_iter

Overview:
- Iterative InvSubBytes stage for the AES decryption datapath; the inverse of the encryption-side byte substitution.
- Applies the inverse S-box to all 16 bytes of a 128-bit state, LANES bytes per clock, so the S-box instance count stays small.
- Sits between the inverse-shift-rows and add-round-key stages of the decryption round.
- Uses a valid/ready handshake on both sides, so the round controller can stall it.

Parameters:
- LANES, 4, bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16; any other value is a compile-time error.
- NSTEP, 16/LANES, derived constant (not overridable): number of BUSY cycles per block.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset (assertion takes effect immediately; release is synchronous to clk by the system).
- in_valid  in  1  inputdata is valid.
- in_ready  out  1  block can accept a new state.
- inputdata  in  128  cipher state; byte0 = [127:120], byte15 = [7:0], column-major as in the encryption path.
- out_valid  out  1  outputdata holds a finished result.
- out_ready  in  1  downstream accepts the result.
- outputdata  out  128  inverse-substituted state, same byte ordering.

Behaviour:
- Reset (rst_n low): state=IDLE, step counter=0, internal 128-bit register=0; outputs in_ready=0, out_valid=0, outputdata=0. A block in flight is discarded; no partial result is ever presented. First cycle after release: in_ready=1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, capture inputdata into the state register, step=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, replace bytes [step*LANES .. step*LANES+LANES-1] (byte0 first) with InvSbox(byte). Then step=step+1.
  - BUSY exit: on the cycle where step==NSTEP-1, go to DONE and clear step to 0.
  - DONE: out_valid=1, outputdata=register, in_ready=0. On out_ready, go to IDLE. Without out_ready, hold the state indefinitely with outputdata stable.
- Latency: from the accepting edge to out_valid high is exactly NSTEP rising edges (LANES=4 gives 4; LANES=16 gives 1).
- Throughput: one block per NSTEP+2 cycles when out_ready is held high (accept, NSTEP BUSY, DONE, IDLE).
- No overlap: in_ready is low in BUSY and DONE. in_valid asserted in DONE is ignored until IDLE is reached.
- outputdata reads 0 outside DONE; it never exposes partially substituted data.
- in_valid/inputdata changing during BUSY has no effect.
- out_ready asserted outside DONE has no effect.
- Step counter width: clog2(NSTEP) with a 1-bit minimum. It never wraps past NSTEP-1.
- Inverse S-box: pure combinational 8-to-8 lookup per FIPS-197 Fig. 14. The byte mux/demux is indexed by step.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM state encoding (IDLE/BUSY/DONE);
  - the AES_STATE_W=128 and BYTE_W=8 constants;
  - the 256-entry inverse S-box constant function, also reusable by key-expansion checks.
- One natural sub-module: inv_sbox (din[7:0] -> dout[7:0], combinational). It is instantiated LANES times, mirroring the encryption-side S-box.

Test Plan:
- Reset: hold rst_n low 3 cycles, then release -> in_ready=1, out_valid=0, outputdata=0. Assert rst_n low mid-BUSY -> outputs drop to 0 immediately and no out_valid follows.
- All-0x63 input, LANES=4, out_ready=1 -> out_valid rises exactly 4 edges after accept; outputdata=0x000...0 (128 bits).
- All-zero input -> outputdata=0x5252...52. Input 0x7c repeated -> 0x0101...01. Input 0x16 repeated -> 0xffff...ff.
- FIPS-197 C.1 inverse round 1: inputdata=0x7a9f102789d5f50b2beffd9f3dca4ea7 -> outputdata=0xbd6e7c3df2b5779e0b61216e8b10b689. Repeat for LANES=1, 2, 8, 16; latency is 16, 8, 2, 1 respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid and inputdata -> outputdata stable, in_ready=0. Then out_ready=1 for one cycle -> IDLE next cycle.
- Round trip: 200 random states through the existing encryption subbytes then this block -> output equals the original; back-to-back in_valid gives one accept per NSTEP+2 cycles.
